// File: rtl/layer2_classifier.sv
// Layer-2 classifier: packed activations from SDRAM, weights from BRAM, argmax out.
// Optional LAYER2_WRITE_SCORE_EN also writes the winning score to RES_ADDR+1.
module layer2_classifier #(
  parameter int N_IN     = 200,
  parameter int N_OUT    = 10,
  parameter int ACT_BASE = 57000,
  parameter int RES_ADDR = 57100,
  parameter int W_BASE   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        done,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [15:0] readdata,
  output logic        read_n,
  output logic        write_n,
  output logic        chipselect,
  output logic [1:0]  byteenable,
  output logic [31:0] address,
  output logic [15:0] writedata,
  output logic [16:0] w_adr,
  output logic        w_cs,
  input  logic [7:0]  w_q,
  output logic [3:0]  class_out,
  output logic [3:0]  state
);

  localparam int NW = (N_IN + 15) / 16;
  localparam int AW = NW * 16;
  localparam logic [3:0]  NW_C   = 4'(NW);
  localparam logic [3:0]  LAST   = 4'(N_OUT - 1);
  localparam logic [7:0]  NIN_C  = 8'(N_IN);
  localparam logic [16:0] STRIDE = 17'(N_IN + 1);
  localparam logic [16:0] WB     = 17'(W_BASE);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_BIAS  = 4'd2,
    S_ACCUM = 4'd3,
    S_CMP   = 4'd4,
    S_WRITE = 4'd5,
    S_DONE  = 4'd6
  } st_t;

  st_t st, st_nx;

  logic [3:0]  sent, rcv, node, best;
  logic [7:0]  cnt;
  logic [7:0]  ai;
  logic [AW-1:0] act;
  logic [16:0] nbase;
  logic signed [15:0] acc, max_q;
  logic signed [15:0] wext;
  logic        rd_go;
`ifdef LAYER2_WRITE_SCORE_EN
  logic        wsel;
`endif

  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign w_cs       = 1'b1;
  assign state      = st;
  assign done       = (st == S_DONE);
  assign wext       = {{8{w_q[7]}}, w_q};
  assign ai         = cnt - 8'd1;
  assign rd_go      = (st == S_FETCH) && (sent < NW_C);

  // state register
  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nx;
  end

  // next state and combinational bus/BRAM strobes
  always_comb begin
    st_nx     = st;
    read_n    = 1'b1;
    write_n   = 1'b1;
    address   = 32'd0;
    writedata = 16'd0;
    w_adr     = nbase;
    case (st)
      S_IDLE: if (ready) st_nx = S_FETCH;
      S_FETCH: begin
        if (rd_go) begin
          read_n  = 1'b0;
          address = 32'(ACT_BASE) + 32'(sent);
        end
        if (rcv == NW_C) st_nx = S_BIAS;
      end
      S_BIAS: if (cnt == 8'd1) st_nx = S_ACCUM;
      S_ACCUM: begin
        w_adr = nbase + 17'(cnt) + 17'd1;
        if (cnt == NIN_C) st_nx = S_CMP;
      end
      S_CMP: st_nx = (node == LAST) ? S_WRITE : S_BIAS;
      S_WRITE: begin
        write_n = 1'b0;
`ifdef LAYER2_WRITE_SCORE_EN
        address   = wsel ? 32'(RES_ADDR + 1) : 32'(RES_ADDR);
        writedata = wsel ? max_q : {12'b0, best};
        if (!waitrequest && wsel) st_nx = S_DONE;
`else
        address   = 32'(RES_ADDR);
        writedata = {12'b0, best};
        if (!waitrequest) st_nx = S_DONE;
`endif
      end
      S_DONE: if (!ready) st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  // counters, activation capture, accumulate and argmax
  always_ff @(posedge clk) begin
    if (reset) begin
      sent      <= '0;
      rcv       <= '0;
      node      <= '0;
      best      <= '0;
      cnt       <= '0;
      act       <= '0;
      nbase     <= WB;
      acc       <= '0;
      max_q     <= '0;
      class_out <= '0;
`ifdef LAYER2_WRITE_SCORE_EN
      wsel      <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          sent  <= '0;
          rcv   <= '0;
          node  <= '0;
          cnt   <= '0;
          nbase <= WB;
          acc   <= '0;
          max_q <= '0;
`ifdef LAYER2_WRITE_SCORE_EN
          wsel  <= 1'b0;
`endif
        end
        S_FETCH: begin
          if (rd_go && !waitrequest) sent <= sent + 4'd1;
          if (readdatavalid && rcv < NW_C) begin
            act[{rcv, 4'b0} +: 16] <= readdata;
            rcv <= rcv + 4'd1;
          end
        end
        S_BIAS: begin
          if (cnt == 8'd1) begin
            acc <= wext;
            cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ACCUM: begin
          if (cnt != 8'd0 && act[ai]) acc <= acc + wext;
          cnt <= (cnt == NIN_C) ? 8'd0 : cnt + 8'd1;
        end
        S_CMP: begin
          if (node == 4'd0 || acc > max_q) begin
            max_q <= acc;
            best  <= node;
          end
          if (node != LAST) begin
            node  <= node + 4'd1;
            nbase <= nbase + STRIDE;
          end
        end
        S_WRITE: begin
          if (!waitrequest) begin
            class_out <= best;
`ifdef LAYER2_WRITE_SCORE_EN
            wsel <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer2_classifier.sv
// Bench for layer2_classifier: SDRAM/BRAM models, argmax reference, per-cycle monitor.
// Honors LAYER2_WRITE_SCORE_EN for the extra score write.
module tb_layer2_classifier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        done;
  logic        waitrequest = 1'b0;
  logic        readdatavalid = 1'b0;
  logic [15:0] readdata = 16'd0;
  logic        read_n, write_n, chipselect;
  logic [1:0]  byteenable;
  logic [31:0] address;
  logic [15:0] writedata;
  logic [16:0] w_adr;
  logic        w_cs;
  logic [7:0]  w_q = 8'd0;
  logic [3:0]  class_out;
  logic [3:0]  state;

  layer2_classifier dut (
    .clk(clk), .reset(reset), .ready(ready), .done(done),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .read_n(read_n), .write_n(write_n),
    .chipselect(chipselect), .byteenable(byteenable),
    .address(address), .writedata(writedata), .w_adr(w_adr),
    .w_cs(w_cs), .w_q(w_q), .class_out(class_out), .state(state)
  );

  always #5 clk = ~clk;

  logic signed [7:0] bram [0:2047];
  logic [15:0] act_mem [0:15];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stale_until = 0;
  bit stall_en = 1'b0;
  int rstall = 0;
  int wstall = 0;
  logic [3:0] exp_class = 4'd0;

  logic [31:0] snap_addr;
  logic        snap_rn, snap_wn;
  logic [31:0] rd_addr [$];
  logic [31:0] wr_addr [$];
  logic [15:0] wr_data [$];
  logic [31:0] pend_addr [$];
  int          pend_due [$];

  // BRAM: registered read, data one cycle after address
  always @(posedge clk) begin
    if (w_adr < 17'd2048) w_q <= bram[w_adr[10:0]];
    else                  w_q <= 8'd0;
  end

  function automatic logic [15:0] act_word(logic [31:0] a);
    if (a >= 32'd57000 && a < 32'd57016) return act_mem[a - 32'd57000];
    return 16'hDEAD;
  endfunction

  // SDRAM slave: stalls, fixed 2-cycle read latency, write log
  always @(negedge clk) begin
    bit wr;
    cyc++;
    wr = 1'b0;
    if (!stall_en) begin
      rstall = 0;
      wstall = 0;
    end else if (!read_n && address == 32'd57003 && rstall < 5) begin
      wr = 1'b1;
      rstall++;
    end else if (!write_n && wstall < 5) begin
      wr = 1'b1;
      wstall++;
    end
    waitrequest = wr;
    snap_addr = address;
    snap_rn = read_n;
    snap_wn = write_n;
    if (!read_n && !wr) begin
      rd_addr.push_back(address);
      pend_addr.push_back(address);
      pend_due.push_back(cyc + 2);
    end
    if (!write_n && !wr) begin
      wr_addr.push_back(address);
      wr_data.push_back(writedata);
    end
    readdatavalid = 1'b0;
    readdata = 16'd0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      readdatavalid = 1'b1;
      readdata = act_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else if (stale_until > cyc) begin
      readdatavalid = 1'b1;
      readdata = 16'h0000;
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // reference: score_k = bias_k + sum of weights whose activation bit is set
  task automatic model(output int cls, output int score);
    int s;
    cls = 0;
    score = 0;
    for (int k = 0; k < 10; k++) begin
      s = int'(bram[k * 201]);
      for (int i = 0; i < 200; i++)
        if (act_mem[i / 16][i % 16]) s += int'(bram[k * 201 + 1 + i]);
      if (k == 0 || s > score) begin
        score = s;
        cls = k;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) bram[i] = 8'sd0;
    for (int i = 0; i < 16; i++) act_mem[i] = 16'h0000;
  endtask

  task automatic load_case1();
    int b [10] = '{5, 1, 9, 3, 0, 0, 0, 0, 0, 0};
    clear_mem();
    for (int i = 0; i < 13; i++) act_mem[i] = 16'hFFFF;
    for (int k = 0; k < 10; k++) bram[k * 201] = 8'(b[k]);
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_in_time"}, 32'(done), 32'd1);
  endtask

  task automatic run_case(string nm, int lit_cls, int lit_score);
    int c, s, rs, ws, nwr;
    bit ok;
    model(c, s);
    chk({nm, "_model_cls"}, c, lit_cls);
    chk({nm, "_model_score"}, s, lit_score);
    exp_class = c[3:0];
    rs = rd_addr.size();
    ws = wr_addr.size();
    @(negedge clk);
    ready = 1'b1;
    wait_done(nm);
    chk({nm, "_class"}, 32'(class_out), 32'(lit_cls));
    chk({nm, "_reads"}, rd_addr.size() - rs, 32'd13);
    ok = 1'b1;
    for (int j = 0; j < 13; j++)
      if (rs + j >= rd_addr.size() || rd_addr[rs + j] != 32'(57000 + j)) ok = 1'b0;
    chk({nm, "_read_seq"}, 32'(ok), 32'd1);
`ifdef LAYER2_WRITE_SCORE_EN
    nwr = 2;
`else
    nwr = 1;
`endif
    chk({nm, "_writes"}, wr_addr.size() - ws, 32'(nwr));
    if (wr_addr.size() >= ws + 1) begin
      chk({nm, "_waddr"}, wr_addr[ws], 32'd57100);
      chk({nm, "_wdata"}, 32'(wr_data[ws]), 32'(c[3:0]));
    end
`ifdef LAYER2_WRITE_SCORE_EN
    if (wr_addr.size() >= ws + 2) begin
      chk({nm, "_saddr"}, wr_addr[ws + 1], 32'd57101);
      chk({nm, "_sdata"}, 32'(wr_data[ws + 1]), 32'(lit_score[15:0]));
    end
`endif
    rs = rd_addr.size();
    for (int j = 0; j < 5; j++) @(negedge clk);
    chk({nm, "_done_hold"}, 32'(done), 32'd1);
    chk({nm, "_no_restart"}, rd_addr.size() - rs, 32'd0);
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_back_idle"}, 32'(state), 32'd0);
    chk({nm, "_done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int c, s;
    clear_mem();
    fork
      forever begin
        @(posedge clk);
        #1;
        chk("bus_excl", 32'(!read_n && !write_n), 32'd0);
        chk("const_strobes", {chipselect, byteenable, w_cs}, 32'hF);
        if (waitrequest) begin
          chk("stall_addr", address, snap_addr);
          chk("stall_strobes", {read_n, write_n}, {snap_rn, snap_wn});
        end
        if (done) chk("done_class", 32'(class_out), 32'(exp_class));
      end
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", {read_n, write_n, done}, 32'b110);
    chk("rst_addr", address, 32'd0);
    chk("rst_class", 32'(class_out), 32'd0);

    load_case1();
    run_case("bias_only", 2, 9);

    clear_mem();
    act_mem[0] = 16'h0001;
    for (int k = 0; k < 10; k++) bram[k * 201 + 1] = 8'(-k * 10);
    run_case("node0_act", 0, 0);

    clear_mem();
    bram[3 * 201] = 8'sd50;
    bram[7 * 201] = 8'sd50;
    run_case("tie", 3, 50);

    load_case1();
    stall_en = 1'b1;
    run_case("stall", 2, 9);
    chk("stall_read_seen", rstall, 5);
    chk("stall_write_seen", wstall, 5);
    stall_en = 1'b0;

    clear_mem();
    for (int i = 0; i < 13; i++) act_mem[i] = 16'hFFFF;
    for (int i = 0; i < 2010; i++) bram[i] = -8'sd128;
    for (int k = 0; k < 10; k++) bram[k * 201] = 8'sd0;
    bram[6 * 201] = 8'sd100;
    model(c, s);
    exp_class = c[3:0];
    @(negedge clk);
    ready = 1'b1;
    n = 0;
    while (!(state == 4'd3 && w_adr > 17'd804 && w_adr < 17'd1005) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_node4_accum", 32'(state), 32'd3);
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_strobes", {read_n, write_n, done}, 32'b110);
    chk("midrst_addr", address, 32'd0);
    chk("midrst_class", 32'(class_out), 32'd0);
    stale_until = cyc + 3;
    repeat (5) @(negedge clk);
    chk("stale_idle", 32'(state), 32'd0);
    run_case("neg_restart", 6, -25500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
